// File: rtl/tasten_eingabe.sv
// Push-button input peripheral: synchronises and debounces buttons, latches press/release
// events and a press counter, and serves them over the CPU read/write handshake.
module tasten_eingabe #(
  parameter int unsigned TASTEN         = 7,
  parameter int unsigned ENTPRELLZYKLEN = 50000,
  parameter int unsigned ZAEHLERBITS    = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [TASTEN-1:0] Tasten,
  input  logic              LesenAn,
  input  logic              SchreibenAn,
  input  logic [1:0]        Adresse,
  input  logic [31:0]       DatenRein,
  output logic [31:0]       DatenRaus,
  output logic              DatenBereit,
  output logic              DatenGeschrieben
);

  typedef enum logic [1:0] {StBereit, StQuittung, StWarten} bus_state_e;

  bus_state_e state_q, state_d;

  logic [TASTEN-1:0]                  sync1_q, sync2_q;
  logic [TASTEN-1:0]                  stabil_q, stabil_d;
  logic [TASTEN-1:0][ZAEHLERBITS-1:0] zaehler_q, zaehler_d;
  logic [TASTEN-1:0]                  gedrueckt_q, gedrueckt_d;
  logic [TASTEN-1:0]                  losgelassen_q, losgelassen_d;
  logic [15:0]                        anzahl_q, anzahl_d;
  logic [31:0]                        daten_raus_q, daten_raus_d;
  logic                               bereit_q, bereit_d;
  logic                               geschrieben_q, geschrieben_d;

  logic [TASTEN-1:0] steigend, fallend;
  logic [TASTEN-1:0] clr_ged, clr_los;
  logic              clr_anz;
  logic [15:0]       anz_inc;
  logic [31:0]       lesewert;

  // Only the low TASTEN bits of write data are meaningful.
  logic unused_daten;
  assign unused_daten = ^DatenRein[31:TASTEN];

  // Debounce: a differing level must persist for ENTPRELLZYKLEN evaluations.
  always_comb begin
    stabil_d  = stabil_q;
    zaehler_d = zaehler_q;
    for (int i = 0; i < TASTEN; i++) begin
      if (sync2_q[i] == stabil_q[i]) begin
        zaehler_d[i] = '0;
      end else if (zaehler_q[i] == ZAEHLERBITS'(ENTPRELLZYKLEN - 1)) begin
        stabil_d[i]  = sync2_q[i];
        zaehler_d[i] = '0;
      end else begin
        zaehler_d[i] = zaehler_q[i] + ZAEHLERBITS'(1);
      end
    end
    steigend = stabil_d & ~stabil_q;
    fallend  = ~stabil_d & stabil_q;
    anz_inc  = '0;
    for (int i = 0; i < TASTEN; i++) begin
      anz_inc = anz_inc + 16'(steigend[i]);
    end
  end

  always_comb begin
    lesewert = '0;
    unique case (Adresse)
      2'd0: lesewert[TASTEN-1:0] = stabil_q;
      2'd1: lesewert[TASTEN-1:0] = gedrueckt_q;
      2'd2: lesewert[TASTEN-1:0] = losgelassen_q;
      2'd3: lesewert[15:0]       = anzahl_q;
      default: lesewert = '0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    daten_raus_d  = daten_raus_q;
    bereit_d      = 1'b0;
    geschrieben_d = 1'b0;
    clr_ged       = '0;
    clr_los       = '0;
    clr_anz       = 1'b0;
    unique case (state_q)
      StBereit: begin
        // A read takes priority; a simultaneous write is dropped.
        if (LesenAn) begin
          daten_raus_d = lesewert;
          bereit_d     = 1'b1;
          state_d      = StQuittung;
        end else if (SchreibenAn) begin
          geschrieben_d = 1'b1;
          state_d       = StQuittung;
          case (Adresse)
            2'd1:    clr_ged = DatenRein[TASTEN-1:0];
            2'd2:    clr_los = DatenRein[TASTEN-1:0];
            2'd3:    clr_anz = 1'b1;
            default: ;
          endcase
        end
      end
      StQuittung: state_d = StWarten;
      StWarten: begin
        if (!LesenAn && !SchreibenAn) state_d = StBereit;
      end
      default: state_d = StBereit;
    endcase
    // Event set wins over a same-cycle clear.
    gedrueckt_d   = (gedrueckt_q & ~clr_ged) | steigend;
    losgelassen_d = (losgelassen_q & ~clr_los) | fallend;
    anzahl_d      = (clr_anz ? 16'd0 : anzahl_q) + anz_inc;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q       <= StBereit;
      sync1_q       <= '0;
      sync2_q       <= '0;
      stabil_q      <= '0;
      zaehler_q     <= '0;
      gedrueckt_q   <= '0;
      losgelassen_q <= '0;
      anzahl_q      <= '0;
      daten_raus_q  <= '0;
      bereit_q      <= 1'b0;
      geschrieben_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= Tasten;
      sync2_q       <= sync1_q;
      stabil_q      <= stabil_d;
      zaehler_q     <= zaehler_d;
      gedrueckt_q   <= gedrueckt_d;
      losgelassen_q <= losgelassen_d;
      anzahl_q      <= anzahl_d;
      daten_raus_q  <= daten_raus_d;
      bereit_q      <= bereit_d;
      geschrieben_q <= geschrieben_d;
    end
  end

  assign DatenRaus        = daten_raus_q;
  assign DatenBereit      = bereit_q;
  assign DatenGeschrieben = geschrieben_q;

endmodule

// File: tb/tb_tasten_eingabe.sv
// Bench for tasten_eingabe: directed scenarios plus random traffic, all checked every cycle
// against a window-based reference model of debounce, events and bus handshake.
module tb_tasten_eingabe;

  localparam int unsigned T  = 16;
  localparam int unsigned E  = 4;
  localparam int unsigned ZB = 4;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic [T-1:0]  Tasten = '0;
  logic          LesenAn = 1'b0;
  logic          SchreibenAn = 1'b0;
  logic [1:0]    Adresse = '0;
  logic [31:0]   DatenRein = '0;
  logic [31:0]   DatenRaus;
  logic          DatenBereit;
  logic          DatenGeschrieben;

  int checks = 0;
  int errors = 0;
  int n_ber  = 0;
  int n_ges  = 0;

  // Reference model state
  logic [T-1:0] p0, p1, m_stab, m_ged, m_los;
  logic [T-1:0] hist[$];
  logic [15:0]  m_anz;
  logic [31:0]  m_raus;
  logic         m_ber, m_ges;
  int           phase;

  tasten_eingabe #(
    .TASTEN        (T),
    .ENTPRELLZYKLEN(E),
    .ZAEHLERBITS   (ZB)
  ) dut (
    .Clock           (Clock),
    .Reset           (Reset),
    .Tasten          (Tasten),
    .LesenAn         (LesenAn),
    .SchreibenAn     (SchreibenAn),
    .Adresse         (Adresse),
    .DatenRein       (DatenRein),
    .DatenRaus       (DatenRaus),
    .DatenBereit     (DatenBereit),
    .DatenGeschrieben(DatenGeschrieben)
  );

  always #5 Clock = ~Clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_reg(input logic [1:0] a);
    logic [31:0] v;
    v = '0;
    case (a)
      2'd0: v[T-1:0] = m_stab;
      2'd1: v[T-1:0] = m_ged;
      2'd2: v[T-1:0] = m_los;
      default: v[15:0] = m_anz;
    endcase
    return v;
  endfunction

  // One rising edge of the model: a bit flips once the last E synchronised samples
  // all disagree with it.
  task automatic model_edge();
    logic [T-1:0] seen, nstab, rise, fall, clr_g, clr_l;
    logic         clr_a, all_diff;
    int           pops;
    if (Reset) begin
      p0 = '0; p1 = '0; m_stab = '0; m_ged = '0; m_los = '0; m_anz = '0;
      m_raus = '0; m_ber = 1'b0; m_ges = 1'b0; phase = 0;
      hist.delete();
      return;
    end
    seen = p1; p1 = p0; p0 = Tasten;
    hist.push_back(seen);
    if (hist.size() > E) void'(hist.pop_front());
    nstab = m_stab;
    if (hist.size() == E) begin
      for (int i = 0; i < T; i++) begin
        all_diff = 1'b1;
        for (int k = 0; k < E; k++) if (hist[k][i] == m_stab[i]) all_diff = 1'b0;
        if (all_diff) nstab[i] = ~m_stab[i];
      end
    end
    rise = nstab & ~m_stab;
    fall = ~nstab & m_stab;
    m_ber = 1'b0; m_ges = 1'b0; clr_g = '0; clr_l = '0; clr_a = 1'b0;
    if (phase == 0) begin
      if (LesenAn) begin
        m_raus = m_reg(Adresse); m_ber = 1'b1; phase = 1;
      end else if (SchreibenAn) begin
        m_ges = 1'b1; phase = 1;
        if (Adresse == 2'd1) clr_g = DatenRein[T-1:0];
        if (Adresse == 2'd2) clr_l = DatenRein[T-1:0];
        if (Adresse == 2'd3) clr_a = 1'b1;
      end
    end else if (phase == 1) begin
      phase = 2;
    end else if (!LesenAn && !SchreibenAn) begin
      phase = 0;
    end
    pops = 0;
    for (int i = 0; i < T; i++) pops += int'(rise[i]);
    m_ged  = (m_ged & ~clr_g) | rise;
    m_los  = (m_los & ~clr_l) | fall;
    m_anz  = (clr_a ? 16'd0 : m_anz) + 16'(pops);
    m_stab = nstab;
  endtask

  task automatic step();
    @(posedge Clock);
    model_edge();
    @(negedge Clock);
    check_val("bereit", 32'(DatenBereit), 32'(m_ber));
    check_val("geschrieben", 32'(DatenGeschrieben), 32'(m_ges));
    check_val("raus", DatenRaus, m_raus);
    if (DatenBereit) n_ber++;
    if (DatenGeschrieben) n_ges++;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    int n;
    n = 0;
    Adresse = a;
    LesenAn = 1'b1;
    do begin step(); n++; end while (!DatenBereit && n < 8);
    check_val("read_ack", 32'(DatenBereit), 32'd1);
    d = DatenRaus;
    LesenAn = 1'b0;
    steps(2);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] w);
    int n;
    n = 0;
    Adresse = a;
    DatenRein = w;
    SchreibenAn = 1'b1;
    do begin step(); n++; end while (!DatenGeschrieben && n < 8);
    check_val("write_ack", 32'(DatenGeschrieben), 32'd1);
    SchreibenAn = 1'b0;
    steps(2);
  endtask

  initial begin
    logic [31:0] d;
    int n;
    @(negedge Clock);
    steps(3);
    Reset = 1'b0;
    step();
    check_val("rst_raus", DatenRaus, 32'd0);
    check_val("rst_bereit", 32'(DatenBereit), 32'd0);
    check_val("rst_geschr", 32'(DatenGeschrieben), 32'd0);

    n_ber = 0; n_ges = 0;
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), d);
      check_val($sformatf("rst_rd%0d", a), d, 32'd0);
    end
    check_val("rst_n_bereit", 32'(n_ber), 32'd4);
    check_val("rst_n_geschr", 32'(n_ges), 32'd0);

    // Clean press of bit 2: stable on the 6th edge after the input changes.
    Tasten[2] = 1'b1;
    steps(6);
    bus_read(2'd0, d); check_val("press_state", d, 32'h4);
    bus_read(2'd1, d); check_val("press_ged", d, 32'h4);
    bus_read(2'd3, d); check_val("press_anz", d, 32'h1);
    Tasten[2] = 1'b0;
    steps(5);
    bus_read(2'd0, d); check_val("release_not_yet", d, 32'h4);
    steps(4);
    bus_read(2'd0, d); check_val("release_state", d, 32'h0);
    bus_read(2'd2, d); check_val("release_los", d, 32'h4);

    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_write(2'd2, 32'hFFFF_FFFF);
    bus_write(2'd3, 32'h0);
    bus_write(2'd0, 32'hFFFF_FFFF);
    bus_read(2'd0, d); check_val("ro_state", d, 32'h0);

    // Bounce on bit 0, then settle high.
    for (int i = 0; i < 10; i++) begin
      Tasten[0] = ~Tasten[0];
      steps(2);
    end
    Tasten[0] = 1'b1;
    steps(8);
    bus_read(2'd3, d); check_val("bounce_anz", d, 32'h1);
    bus_read(2'd1, d); check_val("bounce_ged", d, 32'h1);
    bus_read(2'd2, d); check_val("bounce_los", d, 32'h0);

    // W1C, and a press landing on the same edge as the clear.
    Tasten[2] = 1'b1;
    steps(8);
    bus_read(2'd1, d); check_val("w1c_pre", d, 32'h5);
    bus_write(2'd1, 32'h1);
    bus_read(2'd1, d); check_val("w1c_clear", d, 32'h4);
    Tasten[0] = 1'b0;
    steps(8);
    Tasten[0] = 1'b1;
    steps(5);
    bus_write(2'd1, 32'h1);
    bus_read(2'd1, d); check_val("w1c_set_wins", d, 32'h5);

    // Held read executes once.
    n_ber = 0;
    Adresse = 2'd0;
    LesenAn = 1'b1;
    steps(8);
    LesenAn = 1'b0;
    steps(2);
    check_val("held_read_once", 32'(n_ber), 32'd1);

    // Read and write together: read wins.
    n_ber = 0; n_ges = 0; n = 0;
    Adresse = 2'd3; DatenRein = '0;
    LesenAn = 1'b1; SchreibenAn = 1'b1;
    do begin step(); n++; end while (!DatenBereit && n < 8);
    LesenAn = 1'b0; SchreibenAn = 1'b0;
    steps(2);
    check_val("both_n_bereit", 32'(n_ber), 32'd1);
    check_val("both_n_geschr", 32'(n_ges), 32'd0);
    bus_read(2'd3, d); check_val("both_anz_kept", d, 32'h3);

    // Random traffic
    Tasten = '0;
    steps(8);
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          Tasten = Tasten ^ T'($urandom);
          steps(int'($urandom_range(1, 8)));
        end
        1: bus_read(2'($urandom_range(0, 3)), d);
        2: bus_write(2'($urandom_range(0, 3)), $urandom);
        default: step();
      endcase
    end

    // Counter wrap
    Tasten = '0;
    steps(8);
    bus_write(2'd3, 32'h0);
    for (int r = 0; r < 4095; r++) begin
      Tasten = '1; steps(5);
      Tasten = '0; steps(5);
    end
    Tasten = 16'h7FFF; steps(5);
    Tasten = '0; steps(8);
    bus_read(2'd3, d); check_val("anz_ffff", d, 32'hFFFF);
    Tasten = 16'h8000;
    steps(8);
    bus_read(2'd3, d); check_val("anz_wrap", d, 32'h0);

    // Reset during WARTEN with the request still held.
    n = 0;
    Adresse = 2'd2;
    LesenAn = 1'b1;
    do begin step(); n++; end while (!DatenBereit && n < 8);
    check_val("pre_rst_raus", DatenRaus, 32'hFFFF);
    step();
    Reset = 1'b1;
    step();
    check_val("wrst_raus", DatenRaus, 32'd0);
    check_val("wrst_bereit", 32'(DatenBereit), 32'd0);
    check_val("wrst_geschr", 32'(DatenGeschrieben), 32'd0);
    Reset = 1'b0;
    step();
    check_val("wrst_fsm_bereit", 32'(DatenBereit), 32'd1);
    LesenAn = 1'b0;
    steps(2);
    steps(8);
    bus_read(2'd1, d); check_val("held_in_reset_press", d, 32'h8000);
    bus_read(2'd3, d); check_val("held_in_reset_anz", d, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
